// File: rtl/upc_count_scan.sv
// Package counter for the shared 7-segment decoder: BCD count of synchronized
// pkt_in rising edges, time-multiplexed one digit at a time onto bcd/digit_en.
module upc_count_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_in,
  input  logic                  clear,
  output logic [3:0]            bcd,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  overflow
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  logic                    sync_a, sync_q, prev_q, inc;
  logic [4*NUM_DIGITS-1:0] count, count_nxt;
  logic                    carry, wrap;
  logic [CW-1:0]           rcnt;
  logic [IW-1:0]           idx, idx_next;
  logic                    tc;

  assign inc = sync_q & ~prev_q;

  // Ripple-carry BCD increment; the carry out of the top digit is the wrap.
  always_comb begin
    count_nxt = count;
    carry     = inc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry)
        count_nxt[4*i +: 4] = (count[4*i +: 4] >= 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
      carry = carry & (count[4*i +: 4] == 4'd9);
    end
    wrap = carry;
  end

  assign tc       = (rcnt == CW'(REFRESH_DIV - 1));
  assign idx_next = !tc ? idx :
                    (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_a <= pkt_in;
      sync_q <= sync_a;
      prev_q <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wrap)
        overflow <= 1'b1;
    end
  end

  // Value and enable are loaded from the same index so the bus never mixes digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt     <= '0;
      idx      <= '0;
      bcd      <= 4'd0;
      digit_en <= ~NUM_DIGITS'(1);
    end else begin
      rcnt     <= tc ? '0 : rcnt + 1'b1;
      idx      <= idx_next;
      bcd      <= count[4*idx_next +: 4];
      digit_en <= ~(NUM_DIGITS'(1) << idx_next);
    end
  end

endmodule

// File: tb/tb_upc_count_scan.sv
// Directed bench for upc_count_scan (4 digits, digit held 4 clocks) with a
// free-running scan reference checked on every falling edge.
module tb_upc_count_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_in = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] bcd;
  logic [3:0] digit_en;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  upc_count_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .clear(clear),
    .bcd(bcd), .digit_en(digit_en), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference scan position: digit held 4 clocks, 4 digits, restarts on reset.
  int         m_cnt = 0;
  int         m_idx = 0;
  bit         mon_en = 1'b0;
  logic [3:0] exp_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_idx = 0;
    end else if (m_cnt == 3) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_en = ~(4'b0001 << m_idx);
      check("scan", {28'd0, digit_en}, {28'd0, exp_en});
    end
  end

  task automatic wait_en(input logic [3:0] want);
    int n = 0;
    while (digit_en !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("wait_en", {28'd0, digit_en}, {28'd0, want});
  endtask

  task automatic read_count(output logic [15:0] v);
    logic [3:0] want;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      wait_en(want);
      v[4*k +: 4] = bcd;
    end
  endtask

  task automatic pulse(input int n, input int ph);
    for (int i = 0; i < n; i++) begin
      pkt_in = 1'b1;
      repeat (ph) @(negedge clk);
      pkt_in = 1'b0;
      repeat (ph) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] cv;

  initial begin
    // 1: reset and scan order
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_bcd", {28'd0, bcd}, 32'd0);
    check("rst_en", {28'd0, digit_en}, 32'he);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    check("hold_d0", {28'd0, digit_en}, 32'he);
    @(negedge clk);
    check("step1", {28'd0, digit_en}, 32'hd);
    repeat (4) @(negedge clk);
    check("step2", {28'd0, digit_en}, 32'hb);
    repeat (4) @(negedge clk);
    check("step3", {28'd0, digit_en}, 32'h7);
    repeat (4) @(negedge clk);
    check("step4", {28'd0, digit_en}, 32'he);

    // 2: thirteen pulses
    pulse(13, 3);
    read_count(cv);
    check("cnt13", {16'd0, cv}, 32'h0013);

    // 3: held level counts once; bcd changes on the 4th falling edge after the rise
    wait_en(4'b1011);
    wait_en(4'b0111);
    repeat (3) @(negedge clk);
    pkt_in = 1'b1;
    @(negedge clk);
    check("hold_en", {28'd0, digit_en}, 32'he);
    check("hold_t1", {28'd0, bcd}, 32'd3);
    @(negedge clk);
    check("hold_t2", {28'd0, bcd}, 32'd3);
    @(negedge clk);
    check("hold_t3", {28'd0, bcd}, 32'd3);
    @(negedge clk);
    check("hold_t4", {28'd0, bcd}, 32'd4);
    repeat (36) @(negedge clk);
    pkt_in = 1'b0;
    repeat (4) @(negedge clk);
    read_count(cv);
    check("cnt14", {16'd0, cv}, 32'h0014);

    // 4: wrap past all-nines
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulse(9999, 2);
    read_count(cv);
    check("cnt9999", {16'd0, cv}, 32'h9999);
    check("ovf_pre", {31'd0, overflow}, 32'd0);
    pulse(1, 3);
    read_count(cv);
    check("cnt_wrap", {16'd0, cv}, 32'h0000);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    pulse(2, 3);
    read_count(cv);
    check("cnt_post", {16'd0, cv}, 32'h0002);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5: clear coincident with an increment
    pulse(40, 3);
    read_count(cv);
    check("cnt42", {16'd0, cv}, 32'h0042);
    pkt_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    pkt_in = 1'b0;
    repeat (4) @(negedge clk);
    read_count(cv);
    check("clr_cnt", {16'd0, cv}, 32'h0000);
    check("clr_ovf", {31'd0, overflow}, 32'd0);

    // 6: reset in the middle of the scan
    pulse(57, 3);
    read_count(cv);
    check("cnt57", {16'd0, cv}, 32'h0057);
    wait_en(4'b1011);
    #2 rst = 1'b1;
    #1;
    check("mid_en", {28'd0, digit_en}, 32'he);
    check("mid_bcd", {28'd0, bcd}, 32'd0);
    check("mid_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_count(cv);
    check("mid_cnt", {16'd0, cv}, 32'h0000);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
